// File: rtl/frame_play_ram.sv
`timescale 1ns/1ps
// ----------------------------------------------------------------------------
// frame_play_ram
//
// Captures one burst-side frame of samples into a simple dual-port frame
// buffer, then plays it back one sample per rising edge of a slow, unrelated
// sample clock (out_clk).
//
// out_clk is not used as a clock. It is sampled as data in the rd_clk
// domain and reduced to a single-cycle rising-edge pulse.
//
// Frames longer than the buffer are truncated to RAM_DEEP samples. The
// overflow is flagged with a one-cycle frame_err pulse. The tail of the
// frame is then swallowed until its s_tlast arrives.
//
// Ports
//   rd_clk     in   sole clock, rising edge
//   rst_n      in   synchronous active-low reset
//   s_data     in   burst-side sample (DATA_WIDTH)
//   s_valid    in   s_data valid
//   s_tlast    in   last sample of the frame
//   s_ready    out  block accepts s_data (low only while playing)
//   out_clk    in   slow sample-rate clock, asynchronous, sampled as data
//   out_data   out  played-out sample, registered (DATA_WIDTH)
//   out_valid  out  out_data holds a frame sample
//   out_tlast  out  out_data holds the last sample of the frame
//   busy       out  high whenever the block is not idle
//   frame_err  out  one-cycle pulse when a frame overflows the buffer
// ----------------------------------------------------------------------------
module frame_play_ram #(
  parameter int RAM_DEEP   = 2048,
  parameter int DATA_WIDTH = 12
) (
  input  logic                  rd_clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_valid,
  input  logic                  s_tlast,
  output logic                  s_ready,
  input  logic                  out_clk,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  output logic                  out_tlast,
  output logic                  busy,
  output logic                  frame_err
);

  // Buffer address width. Pointers are kept 17 bits wide, so that a
  // 65536-deep buffer can still represent len == RAM_DEEP.
  localparam int          AW       = (RAM_DEEP > 1) ? $clog2(RAM_DEEP) : 1;
  localparam logic [16:0] LAST_IDX = 17'(RAM_DEEP - 1);
  localparam logic [16:0] FULL_LEN = 17'(RAM_DEEP);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FILL  = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_PLAY  = 2'd3;

  // Frame buffer. It is intentionally not reset.
  logic [DATA_WIDTH-1:0] mem_q [RAM_DEEP];

  logic [1:0]            state_q,     state_d;
  logic [16:0]           wr_ptr_q,    wr_ptr_d;
  logic [16:0]           rd_ptr_q,    rd_ptr_d;
  logic [16:0]           len_q,       len_d;
  logic                  out_valid_q, out_valid_d;
  logic                  out_tlast_q, out_tlast_d;
  logic                  frame_err_q, frame_err_d;
  logic                  busy_q,      busy_d;
  logic                  s_ready_q,   s_ready_d;
  logic [DATA_WIDTH-1:0] out_data_q;

  // out_clk synchronizer and edge-history stages.
  logic                  sync1_q;
  logic                  sync2_q;
  logic                  hist_q;

  logic                  beat_s;
  logic                  out_pose_s;
  logic                  wr_en_s;
  logic [AW-1:0]         wr_addr_s;
  logic                  rd_en_s;
  logic [AW-1:0]         rd_addr_s;

  // s_ready_q always equals (state_q != ST_PLAY), so this is the accepted-beat
  // condition.
  assign beat_s     = s_valid & s_ready_q;
  // Single-cycle pulse on a rising edge of the synchronized out_clk.
  assign out_pose_s = sync2_q & ~hist_q;
  assign rd_addr_s  = rd_ptr_q[AW-1:0];

  // Next-state, pointer and output-flag logic for the capture/playback FSM.
  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    len_d       = len_q;
    out_valid_d = out_valid_q;
    out_tlast_d = out_tlast_q;
    frame_err_d = 1'b0;
    wr_en_s     = 1'b0;
    wr_addr_s   = wr_ptr_q[AW-1:0];
    rd_en_s     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (beat_s) begin
          wr_en_s   = 1'b1;
          wr_addr_s = {AW{1'b0}};
          wr_ptr_d  = 17'd1;
          if (s_tlast) begin
            // A one-sample frame goes straight to playback.
            len_d    = 17'd1;
            rd_ptr_d = 17'd0;
            state_d  = ST_PLAY;
          end else begin
            state_d  = ST_FILL;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_FILL: begin
        if (beat_s) begin
          wr_en_s  = 1'b1;
          wr_ptr_d = wr_ptr_q + 17'd1;
          if (s_tlast) begin
            // s_tlast takes priority, so a frame of exactly RAM_DEEP samples is not an error.
            len_d    = wr_ptr_q + 17'd1;
            rd_ptr_d = 17'd0;
            state_d  = ST_PLAY;
          end else if (wr_ptr_q == LAST_IDX) begin
            len_d       = FULL_LEN;
            frame_err_d = 1'b1;
            state_d     = ST_DRAIN;
          end else begin
            state_d = ST_FILL;
          end
        end else begin
          state_d = ST_FILL;
        end
      end

      ST_DRAIN: begin
        // Overflow tail: accept beats to keep the source moving, but keep nothing.
        if (beat_s && s_tlast) begin
          rd_ptr_d = 17'd0;
          state_d  = ST_PLAY;
        end else begin
          state_d = ST_DRAIN;
        end
      end

      ST_PLAY: begin
        if (out_pose_s) begin
          if (rd_ptr_q < len_q) begin
            rd_en_s     = 1'b1;
            out_valid_d = 1'b1;
            out_tlast_d = (rd_ptr_q == (len_q - 17'd1));
            rd_ptr_d    = rd_ptr_q + 17'd1;
          end else begin
            // One sample period after the last sample: release the
            // outputs and return to idle. out_data keeps its value.
            out_valid_d = 1'b0;
            out_tlast_d = 1'b0;
            rd_ptr_d    = 17'd0;
            wr_ptr_d    = 17'd0;
            state_d     = ST_IDLE;
          end
        end else begin
          state_d = ST_PLAY;
        end
      end

      default: begin
        state_d     = ST_IDLE;
        wr_ptr_d    = 17'd0;
        rd_ptr_d    = 17'd0;
        len_d       = 17'd0;
        out_valid_d = 1'b0;
        out_tlast_d = 1'b0;
      end
    endcase

    // Registered from the next state so both outputs line up with state_q.
    busy_d    = (state_d != ST_IDLE);
    s_ready_d = (state_d != ST_PLAY);
  end

  // FSM, pointer and registered-output flops.
  always_ff @(posedge rd_clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      wr_ptr_q    <= 17'd0;
      rd_ptr_q    <= 17'd0;
      len_q       <= 17'd0;
      out_valid_q <= 1'b0;
      out_tlast_q <= 1'b0;
      frame_err_q <= 1'b0;
      busy_q      <= 1'b0;
      s_ready_q   <= 1'b1;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      len_q       <= len_d;
      out_valid_q <= out_valid_d;
      out_tlast_q <= out_tlast_d;
      frame_err_q <= frame_err_d;
      busy_q      <= busy_d;
      s_ready_q   <= s_ready_d;
    end
  end

  // Two-stage out_clk synchronizer followed by an edge-history flop.
  always_ff @(posedge rd_clk) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      hist_q  <= 1'b0;
    end else begin
      sync1_q <= out_clk;
      sync2_q <= sync1_q;
      hist_q  <= sync2_q;
    end
  end

  // Buffer write port. No write is allowed on a reset edge, so a reset
  // cannot leave a partial beat behind.
  always_ff @(posedge rd_clk) begin
    if (wr_en_s && rst_n) begin
      mem_q[wr_addr_s] <= s_data;
    end
  end

  // Synchronous read port. It loads the addressed sample straight into
  // out_data, which keeps the latency from out_clk to out_data at 3 edges.
  always_ff @(posedge rd_clk) begin
    if (!rst_n) begin
      out_data_q <= {DATA_WIDTH{1'b0}};
    end else if (rd_en_s) begin
      out_data_q <= mem_q[rd_addr_s];
    end
  end

  assign s_ready   = s_ready_q;
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_tlast = out_tlast_q;
  assign busy      = busy_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_frame_play_ram.sv
`timescale 1ns/1ps
// ----------------------------------------------------------------------------
// tb_frame_play_ram
//
// Bench for frame_play_ram with RAM_DEEP=8 and DATA_WIDTH=12.
// out_clk has a period of 10 rd_clk cycles. Its edges are offset from
// rd_clk, so the sampling point is unambiguous.
//
// Expected samples are queued when a frame is issued. An independent
// monitor pops and compares them 3 rd_clk edges after each out_clk rising
// edge.
// ----------------------------------------------------------------------------
module tb_frame_play_ram;

  localparam int DW   = 12;
  localparam int DEEP = 8;

  logic          rd_clk  = 1'b0;
  logic          out_clk = 1'b0;
  logic          rst_n   = 1'b0;
  logic [DW-1:0] s_data  = '0;
  logic          s_valid = 1'b0;
  logic          s_tlast = 1'b0;
  logic          s_ready;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_tlast;
  logic          busy;
  logic          frame_err;

  int total = 0;
  int bad = 0;
  int err_pulses = 0;
  int e0;
  // Each entry is {tlast, data}.
  logic [DW:0] sb_q[$];

  frame_play_ram #(.RAM_DEEP(DEEP), .DATA_WIDTH(DW)) dut (
    .rd_clk   (rd_clk),
    .rst_n    (rst_n),
    .s_data   (s_data),
    .s_valid  (s_valid),
    .s_tlast  (s_tlast),
    .s_ready  (s_ready),
    .out_clk  (out_clk),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_tlast(out_tlast),
    .busy     (busy),
    .frame_err(frame_err)
  );

  initial forever #5 rd_clk = ~rd_clk;
  initial begin
    #2;
    forever #50 out_clk = ~out_clk;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Count cycles where frame_err is high.
  always @(negedge rd_clk) begin
    if (frame_err === 1'b1) err_pulses <= err_pulses + 1;
  end

  // Monitor: samples the outputs 3 rd_clk edges after each out_clk rise.
  initial begin
    logic [DW:0] e;
    forever begin
      @(posedge out_clk);
      repeat (3) @(posedge rd_clk);
      #1;
      if (out_valid === 1'b1) begin
        if (sb_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_sample: got %0h expected none", out_data);
        end else begin
          e = sb_q.pop_front();
          check("sample_data", 32'(out_data), 32'(e[DW-1:0]));
          check("sample_tlast", 32'(out_tlast), 32'(e[DW]));
        end
      end else begin
        check("tlast_without_valid", 32'(out_tlast), 32'd0);
      end
    end
  end

  task automatic push_exp(input logic [DW-1:0] d, input logic last);
    sb_q.push_back({last, d});
  endtask

  task automatic send_beat(input logic [DW-1:0] d, input logic last, input logic exp_err);
    @(negedge rd_clk);
    s_data  = d;
    s_valid = 1'b1;
    s_tlast = last;
    check("s_ready_beat", 32'(s_ready), 32'd1);
    @(posedge rd_clk);
    #1;
    s_valid = 1'b0;
    s_tlast = 1'b0;
    check("frame_err", 32'(frame_err), 32'(exp_err));
  endtask

  task automatic wait_idle(input string name, input logic [DW-1:0] last_val);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 600 && !done; i++) begin
      @(negedge rd_clk);
      if (busy === 1'b0) done = 1'b1;
    end
    check({name, "_busy"}, 32'(busy), 32'd0);
    check({name, "_pending"}, 32'(sb_q.size()), 32'd0);
    check({name, "_valid_end"}, 32'(out_valid), 32'd0);
    check({name, "_tlast_end"}, 32'(out_tlast), 32'd0);
    check({name, "_data_hold"}, 32'(out_data), 32'(last_val));
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_out_data"}, 32'(out_data), 32'd0);
    check({name, "_out_valid"}, 32'(out_valid), 32'd0);
    check({name, "_out_tlast"}, 32'(out_tlast), 32'd0);
    check({name, "_frame_err"}, 32'(frame_err), 32'd0);
    check({name, "_busy"}, 32'(busy), 32'd0);
    check({name, "_s_ready"}, 32'(s_ready), 32'd1);
  endtask

  initial begin
    // Reset
    repeat (3) @(posedge rd_clk);
    @(negedge rd_clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(negedge rd_clk);
    check_reset_outputs("post_reset");

    // Full 8-sample frame, tlast on the 8th beat: no overflow
    e0 = err_pulses;
    for (int i = 1; i <= 8; i++) push_exp(DW'(i), i == 8);
    for (int i = 1; i <= 8; i++) send_beat(DW'(i), i == 8, 1'b0);
    wait_idle("full", 12'h008);
    check("full_err_count", 32'(err_pulses - e0), 32'd0);

    // Short frame of three samples
    push_exp(12'h00A, 1'b0);
    push_exp(12'h00B, 1'b0);
    push_exp(12'h00C, 1'b1);
    send_beat(12'h00A, 1'b0, 1'b0);
    send_beat(12'h00B, 1'b0, 1'b0);
    send_beat(12'h00C, 1'b1, 1'b0);
    wait_idle("short", 12'h00C);

    // Single-beat frame from idle
    push_exp(12'h005, 1'b1);
    send_beat(12'h005, 1'b1, 1'b0);
    wait_idle("single", 12'h005);

    // Overflow: 12 beats, error on the 8th, beats 9..12 dropped
    e0 = err_pulses;
    for (int i = 1; i <= 8; i++) push_exp(DW'(i), i == 8);
    for (int i = 1; i <= 12; i++) send_beat(DW'(i), i == 12, i == 8);
    wait_idle("overflow", 12'h008);
    check("overflow_err_count", 32'(err_pulses - e0), 32'd1);

    // Hold s_valid high during PLAY: nothing is accepted and the frame is unchanged
    for (int i = 1; i <= 8; i++) push_exp(DW'(12'h030 + i), i == 8);
    for (int i = 1; i <= 8; i++) send_beat(DW'(12'h030 + i), i == 8, 1'b0);
    s_data  = 12'hFFF;
    s_tlast = 1'b1;
    s_valid = 1'b1;
    for (int i = 0; i < 60; i++) begin
      @(negedge rd_clk);
      check("s_ready_play", 32'(s_ready), 32'd0);
    end
    s_valid = 1'b0;
    s_tlast = 1'b0;
    wait_idle("valid_in_play", 12'h038);

    // Reset during FILL: the partial frame must never be played
    send_beat(12'h041, 1'b0, 1'b0);
    send_beat(12'h042, 1'b0, 1'b0);
    send_beat(12'h043, 1'b0, 1'b0);
    @(negedge rd_clk);
    rst_n = 1'b0;
    @(posedge rd_clk);
    #1;
    check_reset_outputs("rst_fill");
    @(negedge rd_clk);
    rst_n = 1'b1;

    // Reset during PLAY after the 4th sample, then a fresh frame
    for (int i = 1; i <= 8; i++) push_exp(DW'(12'h010 + i), i == 8);
    for (int i = 1; i <= 8; i++) send_beat(DW'(12'h010 + i), i == 8, 1'b0);
    begin
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 400 && !seen; i++) begin
        @(negedge rd_clk);
        if (sb_q.size() == 4) seen = 1'b1;
      end
      check("play_reached_4", 32'(sb_q.size()), 32'd4);
    end
    rst_n = 1'b0;
    @(posedge rd_clk);
    #1;
    check_reset_outputs("rst_play");
    sb_q.delete();
    @(negedge rd_clk);
    rst_n = 1'b1;
    push_exp(12'h021, 1'b0);
    push_exp(12'h022, 1'b0);
    push_exp(12'h023, 1'b1);
    send_beat(12'h021, 1'b0, 1'b0);
    send_beat(12'h022, 1'b0, 1'b0);
    send_beat(12'h023, 1'b1, 1'b0);
    wait_idle("after_rst", 12'h023);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/frame_play_ram.md
FRAME_PLAY_RAM -- requirements
Module: frame_play_ram

Interface
REQ-001 SHALL have parameter RAM_DEEP, default 2048, frame buffer depth in samples (power of two, 2..65536).
REQ-002 SHALL have parameter DATA_WIDTH, default 12, sample width in bits.
REQ-003 SHALL have port rd_clk  input  1  sole clock; all logic on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port s_data  input  DATA_WIDTH  burst-side sample.
REQ-006 SHALL have port s_valid  input  1  s_data valid.
REQ-007 SHALL have port s_tlast  input  1  marks last sample of frame.
REQ-008 SHALL have port s_ready  output  1  block accepts s_data.
REQ-009 SHALL have port out_clk  input  1  slow sample-rate clock, asynchronous, treated as data.
REQ-010 SHALL have port out_data  output  DATA_WIDTH  played-out sample, registered.
REQ-011 SHALL have port out_valid  output  1  out_data holds a frame sample.
REQ-012 SHALL have port out_tlast  output  1  out_data holds the last frame sample.
REQ-013 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-014 SHALL have port frame_err  output  1  one-cycle pulse on frame overflow.

Function
REQ-015 SHALL implement states IDLE, FILL, DRAIN, PLAY.
REQ-016 Beat accepted SHALL mean s_valid && s_ready at a rd_clk edge.
REQ-017 s_ready SHALL be 1 in IDLE, FILL, DRAIN; 0 in PLAY.
REQ-018 In IDLE, an accepted beat SHALL write mem[0], set wr_ptr to 1, go to FILL; with s_tlast=1 it SHALL set len=1 and go directly to PLAY.
REQ-019 In FILL, each accepted beat SHALL write mem[wr_ptr] and increment wr_ptr (17-bit counter).
REQ-020 Accepted beat with s_tlast=1 in FILL SHALL set len=wr_ptr+1 and go to PLAY; frames shorter than RAM_DEEP are legal.
REQ-021 Accepted beat at wr_ptr=RAM_DEEP-1 without s_tlast SHALL be written, set len=RAM_DEEP, pulse frame_err one cycle, go to DRAIN.
REQ-022 In DRAIN, accepted beats SHALL be discarded (no write); accepted beat with s_tlast=1 SHALL go to PLAY.
REQ-023 out_clk SHALL pass a 2-FF synchronizer plus one history FF; out_pose = sync2 && !hist.
REQ-024 In PLAY, on each out_pose with rd_ptr<len: out_data<=mem[rd_ptr], out_valid<=1, out_tlast<=(rd_ptr==len-1), rd_ptr++.
REQ-025 In PLAY, on out_pose with rd_ptr==len: out_valid<=0, out_tlast<=0, out_data holds, rd_ptr<=0, wr_ptr<=0, go to IDLE.
REQ-026 out_data SHALL change only on out_pose in PLAY; each sample held exactly one out_clk period.
REQ-027 Latency SHALL be 3 rd_clk edges from first edge sampling out_clk=1 to updated out_data.
REQ-028 out_clk edges outside PLAY SHALL be ignored; PLAY SHALL begin with rd_ptr=0 regardless of out_clk phase.
REQ-029 s_valid during PLAY SHALL have no effect; no beat is lost since s_ready=0.
REQ-030 Memory SHALL be simple dual-port, write on accepted beat, synchronous read.

Reset
REQ-031 rst_n=0 at any edge, including mid-FILL or mid-PLAY, SHALL force state IDLE, wr_ptr=0, rd_ptr=0, len=0, sync/history FFs=0.
REQ-032 During and after reset: out_data=0, out_valid=0, out_tlast=0, frame_err=0, busy=0, s_ready=1 from first edge after rst_n=1.
REQ-033 Reset SHALL NOT clear memory contents; a frame interrupted by reset SHALL never be played.

Verification
REQ-034 RAM_DEEP=8: beats 1..8, tlast on 8th, out_clk period 10 rd_clk -> out_data 1..8 one per period, out_tlast only with 8, then out_valid=0, busy=0.
REQ-035 Short frame 3 beats (0xA,0xB,0xC, tlast on 3rd) -> plays 0xA,0xB,0xC, tlast with 0xC, len=3, frame_err=0.
REQ-036 Single beat 0x5 with tlast in IDLE -> PLAY directly; one sample 0x5 with out_valid=1, out_tlast=1.
REQ-037 RAM_DEEP=8: 12 beats, tlast on 12th -> frame_err pulses once on 8th beat, beats 9..12 discarded, playback 1..8.
REQ-038 rst_n low for 1 cycle during PLAY after 4th sample -> all outputs 0, state IDLE, s_ready=1; next frame plays from its own first sample.
REQ-039 s_valid=1 continuously during PLAY -> s_ready=0 throughout, no memory write, played frame unchanged.
